// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and constants for the binary-clock time-set controller.
// Counter widths are derived from the module parameters via cnt_width().
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_SET_HOURS   = 2'd1,
    ST_SET_MINUTES = 2'd2
  } state_t;

  localparam int unsigned HOURS_MOD   = 24;
  localparam int unsigned MINUTES_MOD = 60;

  // Bits needed to count 0 .. max_count-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count <= 1) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/clock_set_ctrl_button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on the debounced rising edge.
module button_debounce
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          level, level_q;
  logic [CW-1:0] stable_cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_q    <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      // Level flips only after the synchronized input disagrees for
      // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts.
      if (sync2 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: debounced mode/inc buttons drive a RUN/SET_HOURS/
// SET_MINUTES editor that freezes the counters, commits with load, and blinks.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_CYCLES    = 50,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic [4:0] set_hours,
  output logic [5:0] set_minutes,
  output logic       load,
  output logic       hold,
  output logic       blank_hours,
  output logic       blank_minutes,
  output logic [1:0] state
);

  localparam int unsigned   BW         = cnt_width(BLINK_CYCLES);
  localparam int unsigned   TW         = cnt_width(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic          mode_evt, inc_evt;
  state_t        state_q, state_d;
  logic [4:0]    hours_d;
  logic [5:0]    minutes_d;
  logic          load_d, hold_d, blank_hours_d, blank_minutes_d;
  logic [BW-1:0] blink_cnt, blink_cnt_d;
  logic          phase, phase_d;
  logic [TW-1:0] idle_cnt, idle_cnt_d;
  logic          entering, timed_out;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk(clk), .rst(rst), .btn(btn_mode), .press(mode_evt)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk(clk), .rst(rst), .btn(btn_inc), .press(inc_evt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // An event in the same cycle always beats the idle timeout.
  assign timed_out = !mode_evt && !inc_evt && (idle_cnt == IDLE_LAST);

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:         if (mode_evt) state_d = ST_SET_HOURS;
      ST_SET_HOURS:   if (mode_evt) state_d = ST_SET_MINUTES;
                      else if (timed_out) state_d = ST_RUN;
      ST_SET_MINUTES: if (mode_evt || timed_out) state_d = ST_RUN;
      default:        state_d = ST_RUN;
    endcase
  end

  // Next values of every registered output; mode beats a simultaneous inc.
  always_comb begin
    hours_d   = set_hours;
    minutes_d = set_minutes;
    load_d    = 1'b0;
    case (state_q)
      ST_RUN: if (mode_evt) begin
        hours_d   = (cur_hours   >= 5'(HOURS_MOD))   ? '0 : cur_hours;
        minutes_d = (cur_minutes >= 6'(MINUTES_MOD)) ? '0 : cur_minutes;
      end
      ST_SET_HOURS: if (!mode_evt && inc_evt)
        hours_d = (set_hours == 5'(HOURS_MOD - 1)) ? '0 : set_hours + 5'd1;
      ST_SET_MINUTES: begin
        if (mode_evt) load_d = 1'b1;
        else if (inc_evt)
          minutes_d = (set_minutes == 6'(MINUTES_MOD - 1)) ? '0 : set_minutes + 6'd1;
      end
      default: ;
    endcase

    hold_d   = (state_d != ST_RUN);
    entering = (state_d != state_q) && (state_d != ST_RUN);

    if (!hold_d || entering) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase;
    end else begin
      blink_cnt_d = blink_cnt + BW'(1);
      phase_d     = phase;
    end

    if (!hold_d || entering || mode_evt || inc_evt) idle_cnt_d = '0;
    else                                            idle_cnt_d = idle_cnt + TW'(1);

    blank_hours_d   = (state_d == ST_SET_HOURS)   & phase_d;
    blank_minutes_d = (state_d == ST_SET_MINUTES) & phase_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_hours     <= '0;
      set_minutes   <= '0;
      load          <= 1'b0;
      hold          <= 1'b0;
      blank_hours   <= 1'b0;
      blank_minutes <= 1'b0;
      blink_cnt     <= '0;
      phase         <= 1'b0;
      idle_cnt      <= '0;
    end else begin
      set_hours     <= hours_d;
      set_minutes   <= minutes_d;
      load          <= load_d;
      hold          <= hold_d;
      blank_hours   <= blank_hours_d;
      blank_minutes <= blank_minutes_d;
      blink_cnt     <= blink_cnt_d;
      phase         <= phase_d;
      idle_cnt      <= idle_cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed corner sequences, a table
// of full edits, and randomized presses against an event-level model.
module tb_clock_set_ctrl;

  localparam int DB = 4;
  localparam int BL = 8;
  localparam int TO = 64;
  localparam int PRESS_LAT = 2 + DB + 1 + 1;  // raw rise to FSM reaction edge

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic       load, hold, blank_hours, blank_minutes;
  logic [1:0] state;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .set_hours(set_hours), .set_minutes(set_minutes), .load(load),
    .hold(hold), .blank_hours(blank_hours), .blank_minutes(blank_minutes),
    .state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Continuous monitor: hold tracks set modes, load is a lone commit pulse.
  bit mon_en = 1'b0;
  bit prev_load = 1'b0;
  int prev_state = 0;
  int load_seen = 0;
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      check("hold_vs_state", int'(hold), int'(state != 2'd0));
      if (load) begin
        check("load_not_consecutive", int'(prev_load), 0);
        check("load_from_set_minutes", prev_state, 2);
        check("load_state_run", int'(state), 0);
      end
    end
    prev_load  <= load;
    prev_state <= int'(state);
    if (load) load_seen <= load_seen + 1;
  end

  // Press one or both buttons cleanly; returns the edge on which the FSM reacts.
  task automatic press(input bit m, input bit i, output int act);
    act = cyc + PRESS_LAT;
    btn_mode = m;
    btn_inc  = i;
    repeat (10) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  // Event-level reference model: modular arithmetic on field values.
  int m_state = 0, m_h = 0, m_m = 0, m_last = 0, m_loads = 0;

  task automatic model_event(input int edge_no, input bit m, input bit i,
                             input int ch, input int cm);
    if (m_state != 0 && edge_no - m_last > TO) m_state = 0;
    if (m) begin
      if (m_state == 0) begin
        m_h = (ch >= 24) ? 0 : ch;
        m_m = (cm >= 60) ? 0 : cm;
        m_state = 1;
      end else if (m_state == 1) begin
        m_state = 2;
      end else begin
        m_state = 0;
        m_loads++;
      end
    end else if (i) begin
      if (m_state == 1) m_h = (m_h + 1) % 24;
      if (m_state == 2) m_m = (m_m + 1) % 60;
    end
    m_last = edge_no;
  endtask

  typedef struct {
    int ch, cm, ih, im, eh, em;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #(20000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, a2, loads0, hh;

    vecs[0] = '{ch: 22, cm: 58, ih: 3, im: 2,  eh: 1,  em: 0};
    vecs[1] = '{ch: 23, cm: 59, ih: 1, im: 1,  eh: 0,  em: 0};
    vecs[2] = '{ch: 30, cm: 61, ih: 0, im: 0,  eh: 0,  em: 0};
    vecs[3] = '{ch: 5,  cm: 10, ih: 2, im: 5,  eh: 7,  em: 15};
    vecs[4] = '{ch: 12, cm: 45, ih: 0, im: 15, eh: 12, em: 0};
    vecs[5] = '{ch: 24, cm: 60, ih: 1, im: 0,  eh: 1,  em: 0};

    // Reset state
    idle(3);
    check("rst_state", int'(state), 0);
    check("rst_set_hours", int'(set_hours), 0);
    check("rst_set_minutes", int'(set_minutes), 0);
    check("rst_load", int'(load), 0);
    check("rst_hold", int'(hold), 0);
    check("rst_blank_hours", int'(blank_hours), 0);
    check("rst_blank_minutes", int'(blank_minutes), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(1);

    // Bounce: 20 cycles of 2-cycle toggling, then a steady press
    cur_hours = 5'd9;
    cur_minutes = 6'd30;
    for (int k = 0; k < 10; k++) begin
      btn_mode = (k % 2 == 0);
      idle(2);
    end
    check("bounce_no_event", int'(state), 0);
    btn_mode = 1'b1;
    idle(PRESS_LAT - 1);
    check("bounce_before_latency", int'(state), 0);
    idle(1);
    check("bounce_enter_set_hours", int'(state), 1);
    btn_mode = 1'b0;
    idle(8);
    pulse_reset();
    check("reset_after_bounce", int'(state), 0);

    // Blink on a fresh SET_HOURS entry
    btn_mode = 1'b1;
    idle(PRESS_LAT);
    for (int k = 0; k < 24; k++) begin
      if (k == 2) btn_mode = 1'b0;
      check("blink_state", int'(state), 1);
      check("blink_hours", int'(blank_hours), (k / BL) % 2);
      check("blink_minutes", int'(blank_minutes), 0);
      idle(1);
    end

    // Collision: mode and inc in the same cycle, then reset mid-edit
    loads0 = load_seen;
    press(1'b1, 1'b1, a);
    check("collide_state", int'(state), 2);
    check("collide_hours", int'(set_hours), 9);
    rst = 1'b1;
    idle(1);
    check("rst_edit_state", int'(state), 0);
    check("rst_edit_hours", int'(set_hours), 0);
    check("rst_edit_minutes", int'(set_minutes), 0);
    check("rst_edit_hold", int'(hold), 0);
    check("rst_edit_load", int'(load), 0);
    check("rst_edit_blank", int'(blank_hours | blank_minutes), 0);
    rst = 1'b0;
    idle(4);
    check("rst_edit_no_load", load_seen - loads0, 0);

    // Timeout: one inc, then idle until abandoned
    cur_hours = 5'd23;
    cur_minutes = 6'd10;
    loads0 = load_seen;
    press(1'b1, 1'b0, a);
    press(1'b0, 1'b1, a);
    check("to_inc_wrap_hours", int'(set_hours), 0);
    idle(a + TO - 1 - cyc);
    check("to_before_limit", int'(state), 1);
    idle(1);
    check("to_state_run", int'(state), 0);
    check("to_hold_drop", int'(hold), 0);
    check("to_stale_hours", int'(set_hours), 0);

    // Timeout boundary: event exactly on the limit edge wins, one later loses
    press(1'b1, 1'b0, a);
    idle(a + TO - PRESS_LAT - cyc);
    press(1'b0, 1'b1, a2);
    check("to_edge_event_wins", int'(state), 1);
    check("to_edge_hours", int'(set_hours), 0);
    idle(a2 + TO + 1 - PRESS_LAT - cyc);
    press(1'b0, 1'b1, a);
    check("to_past_limit_state", int'(state), 0);
    check("to_past_limit_hours", int'(set_hours), 0);
    check("to_no_load", load_seen - loads0, 0);

    // Table of complete edits
    for (int v = 0; v < 6; v++) begin
      cur_hours   = 5'(vecs[v].ch);
      cur_minutes = 6'(vecs[v].cm);
      loads0 = load_seen;
      press(1'b1, 1'b0, a);
      check("tbl_enter", int'(state), 1);
      for (int n = 0; n < vecs[v].ih; n++) press(1'b0, 1'b1, a);
      press(1'b1, 1'b0, a);
      check("tbl_set_minutes_state", int'(state), 2);
      check("tbl_hours_mid", int'(set_hours), vecs[v].eh);
      for (int n = 0; n < vecs[v].im; n++) press(1'b0, 1'b1, a);
      press(1'b1, 1'b0, a);
      check("tbl_state_run", int'(state), 0);
      check("tbl_hours", int'(set_hours), vecs[v].eh);
      check("tbl_minutes", int'(set_minutes), vecs[v].em);
      check("tbl_one_load", load_seen - loads0, 1);
    end

    // Randomized presses against the model
    pulse_reset();
    m_state = 0; m_h = 0; m_m = 0; m_last = 0; m_loads = 0;
    loads0 = load_seen;
    for (int n = 0; n < 40; n++) begin
      int gap, r;
      bit pm, pi;
      gap = $urandom_range(0, 60);
      idle(gap);
      cur_hours   = 5'($urandom_range(0, 31));
      cur_minutes = 6'($urandom_range(0, 63));
      r  = $urandom_range(0, 9);
      pm = (r < 4) || (r == 9);
      pi = (r >= 4);
      hh = int'(cur_hours);
      press(pm, pi, a);
      model_event(a, pm, pi, hh, int'(cur_minutes));
      check("rnd_state", int'(state), m_state);
      check("rnd_hours", int'(set_hours), m_h);
      check("rnd_minutes", int'(set_minutes), m_m);
    end
    idle(2);
    check("rnd_loads", load_seen - loads0, m_loads);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Time-set controller for the binary clock. It debounces two raw push-buttons and runs a set-mode FSM (RUN -> SET_HOURS -> SET_MINUTES -> RUN). While the user edits a working copy of hours/minutes, it freezes the time counters, then commits the edited value with a one-cycle load strobe. It also produces blink enables so the display can flash the field being edited.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced level changes
BLINK_CYCLES, 50, cycles per blink half-period in set modes
TIMEOUT_CYCLES, 1000, idle cycles in a set mode before abandoning the edit

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
btn_mode  input  1  raw mode button, asynchronous, active-high
btn_inc  input  1  raw increment button, asynchronous, active-high
cur_hours  input  5  live hours from the time counters, 0..23
cur_minutes  input  6  live minutes from the time counters, 0..59
set_hours  output  5  working/commit hours value
set_minutes  output  6  working/commit minutes value
load  output  1  one-cycle pulse: counters take set_hours/set_minutes
hold  output  1  high while in a set mode; counters must not advance
blank_hours  output  1  display blanks hours field this cycle
blank_minutes  output  1  display blanks minutes field this cycle
state  output  2  0=RUN, 1=SET_HOURS, 2=SET_MINUTES

Behaviour:
- Reset: clk and rst only; reset is synchronous, active-high.
  - All outputs go to 0 and state to RUN.
  - Synchronizers, debounced levels and all counters clear.
  - Reset in a set mode discards the edit; no load is issued.
- Debounce (per button):
  - 2-flop synchronizer feeds a stability counter.
  - The debounced level flips only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
  - A press event is a 1-cycle pulse on the debounced 0->1 edge. Release produces no event.
  - Latency from raw rise to event: 2 + DEBOUNCE_CYCLES + 1 cycles.
- RUN:
  - hold=0; blank_* = 0.
  - mode_evt: capture cur_hours/cur_minutes into set_hours/set_minutes (values >=24 / >=60 clamp to 0), go to SET_HOURS next cycle.
  - inc_evt: ignored.
- SET_HOURS:
  - hold=1.
  - inc_evt: set_hours = 23 -> 0, else +1.
  - mode_evt: go to SET_MINUTES.
- SET_MINUTES:
  - hold=1.
  - inc_evt: set_minutes = 59 -> 0, else +1.
  - mode_evt: go to RUN; load=1 for exactly that one cycle, with hold=0 in the same cycle.
- Simultaneous mode_evt and inc_evt in one cycle: mode wins, inc discarded.
- Timeout:
  - The idle counter clears on entering a set mode and on every event.
  - On reaching TIMEOUT_CYCLES-1 in a set mode, return to RUN with no load; set_* keep stale values.
- Blink:
  - The phase counter runs only in set modes and restarts at 0 with phase=0 (visible) on entering SET_HOURS or SET_MINUTES.
  - Phase toggles every BLINK_CYCLES.
  - blank_hours = (state==SET_HOURS) & phase; blank_minutes = (state==SET_MINUTES) & phase.
- All outputs are registered. load is never asserted in two consecutive cycles.

Decomposition:
- Shared package:
  - state encodings ST_RUN / ST_SET_HOURS / ST_SET_MINUTES.
  - HOURS_MOD=24, MINUTES_MOD=60.
  - Counter widths derived via $clog2 of the parameters.
- One natural sub-module: button_debounce (synchronizer, stability counter, rising-edge pulse), instantiated twice.
- FSM, blink and timeout logic live in clock_set_ctrl.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, TIMEOUT_CYCLES=64.
1. Bounce: btn_mode toggles every 2 cycles for 20 cycles, then holds high -> exactly one mode event, arriving 7 cycles after the final rise; state goes 0 -> 1.
2. Full edit: cur 22:58; mode, inc x3, mode, inc x2, mode -> set_hours 1, set_minutes 0; load high exactly 1 cycle as state returns to 0; hold high only during states 1-2.
3. Wrap: in SET_MINUTES from 59, one inc -> 0; in SET_HOURS from 23, one inc -> 0.
4. Timeout: enter SET_HOURS, inc once, then idle 64 cycles -> state 0, load never asserted, hold drops.
5. Collision and reset: mode_evt and inc_evt forced in the same cycle in SET_HOURS -> state 2, set_hours unchanged. Then rst high 1 cycle in SET_MINUTES -> state 0, all outputs 0, no load.
6. Blink: in SET_HOURS, blank_hours = 0 for cycles 0-7, 1 for 8-15, 0 for 16-23 after entry; blank_minutes stays 0 throughout.
